// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcodes and fetch FSM states for the CPU.
package cpu_pkg;
    localparam int BUS_WIDTH = 16;
    localparam int PC_WIDTH = 8;
    localparam int TIMEOUT = 15;
    localparam logic [3:0] OP_START = 4'h0;
    localparam logic [3:0] OP_END = 4'hF;
    typedef enum logic [1:0] {IDLE, REQ, DONE} fetch_state_t;
    function automatic logic [BUS_WIDTH-1:0] op_word(input logic [3:0] op);
        return {op, {(BUS_WIDTH-4){1'b0}}};
    endfunction
endpackage

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: instruction memory read bus between fetch stage and memory.
interface ifetch_unit_if;
    import cpu_pkg::*;
    logic [PC_WIDTH-1:0] imem_addr;
    logic imem_req;
    logic [BUS_WIDTH-1:0] imem_rdata;
    logic imem_rvalid;
    modport master(output imem_addr, imem_req, input imem_rdata, imem_rvalid);
    modport slave(input imem_addr, imem_req, output imem_rdata, imem_rvalid);
endinterface

// File: rtl/ifetch_pc.sv
// ifetch_pc: program counter with jump-over-increment priority.
module ifetch_pc
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic jump,
    input  logic alu_zero,
    input  logic pc_inc,
    input  logic [PC_WIDTH-1:0] target,
    output logic [PC_WIDTH-1:0] pc
);
    logic [PC_WIDTH-1:0] pc_nx;
    // an untaken JUMPNZ still steps over its target word
    always_comb pc_nx = jump ? (alu_zero ? pc + 1'b1 : target) : pc_inc ? pc + 1'b1 : pc;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) pc <= '0;
        else pc <= pc_nx;
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch stage owning PC, IR and IMM; define IFETCH_TIMEOUT_EN
// to abort memory reads that never return.
module ifetch_unit
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic imem_read,
    input  logic dst_imm,
    input  logic pc_inc,
    input  logic jump,
    input  logic alu_zero,
    ifetch_unit_if.master mem,
    output logic [BUS_WIDTH-1:0] ir,
    output logic [BUS_WIDTH-1:0] imm,
    output logic [PC_WIDTH-1:0] pc,
    output logic busy,
    output logic fetch_done,
    output logic fault
);
    fetch_state_t state, state_nx;
    logic dst, accept, capture, expire;
    logic [BUS_WIDTH-1:0] word;
`ifdef IFETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] cnt;
    assign expire = state == REQ && !mem.imem_rvalid && cnt == TW'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else cnt <= (state == REQ && !mem.imem_rvalid) ? cnt + 1'b1 : '0;
`else
    assign expire = 1'b0;
`endif
    assign accept = imem_read && state != REQ;
    assign capture = state == REQ && (mem.imem_rvalid || expire);
    // a timed-out read delivers START so the control unit restarts
    assign word = mem.imem_rvalid ? mem.imem_rdata : op_word(OP_START);
    assign mem.imem_req = state == REQ;
    assign busy = state == REQ;
    assign fetch_done = state == DONE;
    always_comb begin
        state_nx = state;
        if (accept) state_nx = REQ;
        else if (capture) state_nx = DONE;
        else if (state == DONE) state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            mem.imem_addr <= '0;
            dst <= 1'b0;
            ir <= '0;
            imm <= '0;
            fault <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                mem.imem_addr <= pc;
                dst <= dst_imm;
            end
            if (capture && dst) imm <= word;
            if (capture && !dst) ir <= word;
            fault <= fault | (imem_read && state == REQ) | expire;
        end
    ifetch_pc u_pc (
        .clk(clk),
        .reset_n(reset_n),
        .jump(jump),
        .alu_zero(alu_zero),
        .pc_inc(pc_inc),
        .target(imm[PC_WIDTH-1:0]),
        .pc(pc)
    );
endmodule
